// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage types and constants for the RV32I pipeline.
// Holds the fetch-entry record layout, the FSM encoding and reset defaults.
// No logic; imported by the fetch stage and its FIFO.
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        misaligned;
    } fetch_entry_t;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// 2-entry fetch-entry FIFO; slot0 is always the head, so head outputs are flops.
// Latency: an entry written at edge n is visible on head in cycle n+1.
// Backpressure: a push into a full FIFO is dropped unless the head pops on the same edge.
module fetch_fifo
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enq,
    input  logic         deq,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         deq_ok;
    logic         enq_ok;

    assign deq_ok = deq && (count != 2'd0);
    assign enq_ok = enq && ((count != 2'd2) || deq_ok);
    assign head   = slot0;

    // Flush only clears occupancy; the stale head value stays on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({enq_ok, deq_ok})
                2'b10: begin
                    if (count == 2'd0) slot0 <= din;
                    else               slot1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC register, FETCH/HALT FSM, redirect handling, 2-entry output FIFO.
// Latency: word fetched at imem_pc in cycle n appears on out_* in cycle n+1.
// Backpressure: out_ready low fills the FIFO, then fetch stalls with the PC held.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_misaligned
);

    localparam logic [1:0] CNT_FULL = DEPTH[1:0];

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc;
    logic [1:0]   count;
    logic         enq;
    logic         deq;
    logic         misaligned;
    fetch_entry_t enq_dat;
    fetch_entry_t head;

    assign imem_pc    = pc;
    assign misaligned = (pc[1:0] != 2'b00);
    assign deq        = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_nxt;
    end

    // A misaligned target is pushed once as a marker, then fetch parks until redirected.
    always_comb begin
        state_nxt = state;
        if (redirect_valid)           state_nxt = ST_FETCH;
        else if (enq && misaligned)   state_nxt = ST_HALT;
    end

    always_comb begin
        enq = 1'b0;
        if (state == ST_FETCH && !redirect_valid && ((count < CNT_FULL) || deq))
            enq = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  pc <= RESET_PC;
        else if (redirect_valid)     pc <= redirect_pc;
        else if (enq && !misaligned) pc <= pc + 32'd4;
    end

    always_comb begin
        enq_dat.pc         = pc;
        enq_dat.inst       = misaligned ? 32'h0 : imem_inst;
        enq_dat.misaligned = misaligned;
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .enq   (enq),
        .deq   (deq),
        .flush (redirect_valid),
        .din   (enq_dat),
        .head  (head),
        .count (count)
    );

    assign out_valid      = (count != 2'd0);
    assign out_pc         = head.pc;
    assign out_inst       = head.inst;
    assign out_misaligned = head.misaligned;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a behavioural instruction memory and an expected-entry queue.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misaligned;

    int vectors;
    int miscompares;
    fetch_entry_t exp_q[$];

    if_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_misaligned (out_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_inst = mem_word(imem_pc);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic mis);
        fetch_entry_t e;
        e.pc         = pc;
        e.inst       = mis ? 32'h0 : mem_word(pc);
        e.misaligned = mis;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        fetch_entry_t e;
        check({tag, ".valid"}, {31'h0, out_valid}, 32'd1);
        vectors++;
        assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, ".pc"},   out_pc,   e.pc);
            check({tag, ".inst"}, out_inst, e.inst);
            check({tag, ".mis"},  {31'h0, out_misaligned}, {31'h0, e.misaligned});
        end
    endtask

    task automatic do_reset(input logic ready);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = ready;
        exp_q.delete();
        step();
        step();
        check("rst.imem_pc", imem_pc, RESET_PC_DFLT);
        check("rst.valid",   {31'h0, out_valid}, 32'd0);
        check("rst.out_pc",  out_pc,   32'h0);
        check("rst.out_inst", out_inst, 32'h0);
        check("rst.mis",     {31'h0, out_misaligned}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset and free-run
        do_reset(1'b1);
        check("run.first_empty", {31'h0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4), 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            pop_check("run");
            step();
        end

        // Back-pressure from reset
        do_reset(1'b0);
        repeat (5) step();
        check("bp.imem_pc", imem_pc, 32'd8);
        check("bp.head_pc", out_pc, 32'd0);
        check("bp.valid", {31'h0, out_valid}, 32'd1);
        out_ready = 1'b1;
        push_exp(32'd0, 1'b0);
        push_exp(32'd4, 1'b0);
        push_exp(32'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pop_check("bp");
            step();
        end
        check("bp.drained", 32'(exp_q.size()), 32'd0);

        // Redirect with a full FIFO
        out_ready = 1'b0;
        check("redir.full_head", out_pc, 32'd12);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("redir.flushed", {31'h0, out_valid}, 32'd0);
        check("redir.imem_pc", imem_pc, 32'h100);
        push_exp(32'h100, 1'b0);
        step();
        pop_check("redir");
        step();

        // Misaligned redirect; the head dequeued in the redirect cycle still completes
        push_exp(32'h104, 1'b0);
        pop_check("mis.pre");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
        check("mis.empty", {31'h0, out_valid}, 32'd0);
        check("mis.imem_pc", imem_pc, 32'h102);
        push_exp(32'h102, 1'b1);
        step();
        pop_check("mis");
        for (int i = 0; i < 3; i++) begin
            step();
            check("mis.halt_valid", {31'h0, out_valid}, 32'd0);
            check("mis.halt_pc", imem_pc, 32'h102);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        check("resume.imem_pc", imem_pc, 32'h200);
        push_exp(32'h200, 1'b0);
        push_exp(32'h204, 1'b0);
        step();
        pop_check("resume");
        step();
        pop_check("resume");

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap.imem_pc", imem_pc, 32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC, 1'b0);
        push_exp(32'h0, 1'b0);
        push_exp(32'h4, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            pop_check("wrap");
            step();
        end

        // Asynchronous reset with two entries buffered
        out_ready = 1'b0;
        step();
        check("arst.pre_valid", {31'h0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid",   {31'h0, out_valid}, 32'd0);
        check("arst.imem_pc", imem_pc, RESET_PC_DFLT);
        check("arst.out_pc",  out_pc,  32'h0);
        check("arst.out_inst", out_inst, 32'h0);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        step();
        check("arst.restart_pc", imem_pc, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
